voice_allocator: RTL and testbench

Polyphony controller for the 12-note synth datapath. It debounces the 12 raw note keys and grants at most `MAX_VOICES` of them. It drives the signal mixer's `sample_enable` mask and commits mask changes only on the sample-rate strobe, so the mixed sample never changes voice set mid-sample. It sits between the push-button inputs and `signal_mixer`, alongside `sample_rate_clkdiv`.

---
 rtl/voice_allocator.sv | 131 +++++++++++++
 tb/tb_voice_allocator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - debounced note-key polyphony allocator with strobe-aligned mask commit
module voice_allocator #(
  parameter int NKEYS      = 12,
  parameter int MAX_VOICES = 4,
  parameter int DB_CYCLES  = 100000
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [NKEYS-1:0]                keys,
  input  logic                            sample_now,
  output logic [NKEYS-1:0]                sample_enable,
  output logic [$clog2(MAX_VOICES+1)-1:0] active_count,
  output logic                            overflow
);

  localparam int CW = $clog2(MAX_VOICES + 1);
  localparam int PW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int TW = $clog2(DB_CYCLES);

  localparam logic [TW-1:0] TICK_LAST = TW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NKEYS - 1);
  localparam logic [CW-1:0] VMAX      = CW'(MAX_VOICES);

  typedef enum logic [1:0] {LOAD, SCAN, HOLD} state_t;

  state_t           state;
  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] ksync;
  logic [NKEYS-1:0] prev;
  logic [NKEYS-1:0] stable;
  logic [NKEYS-1:0] snap;
  logic [NKEYS-1:0] shadow;
  logic [TW-1:0]    tick_cnt;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    ptr;
  logic             tick;
  logic [NKEYS-1:0] held_granted;
  logic [NKEYS-1:0] disagree;

  // Number of set bits; callers only pass masks that hold at most MAX_VOICES ones
  function automatic logic [CW-1:0] popcount(input logic [NKEYS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NKEYS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  assign tick         = (tick_cnt == TICK_LAST);
  assign held_granted = sample_enable & stable;
  assign disagree     = ksync ^ prev;

  // Two-flop synchronizer for the asynchronous push-buttons
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= '0;
      ksync <= '0;
    end else begin
      sync1 <= keys;
      ksync <= sync1;
    end
  end

  // Shared debounce tick counter, wraps after DB_CYCLES clocks
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // A key level is accepted only when it agrees on two consecutive ticks
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev   <= '0;
      stable <= '0;
    end else if (tick) begin
      prev   <= ksync;
      stable <= (stable & disagree) | (ksync & ~disagree);
    end
  end

  // Allocation pass: keep held grants, add new keys lowest index first, commit on the strobe
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= LOAD;
      snap          <= '0;
      shadow        <= '0;
      cnt           <= '0;
      ptr           <= '0;
      sample_enable <= '0;
      active_count  <= '0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          snap   <= stable;
          shadow <= held_granted;
          cnt    <= popcount(held_granted);
          ptr    <= '0;
          state  <= SCAN;
        end
        SCAN: begin
          if (snap[ptr] && !shadow[ptr] && (cnt < VMAX)) begin
            shadow[ptr] <= 1'b1;
            cnt         <= cnt + CW'(1);
          end
          if (ptr == PTR_LAST) begin
            state <= HOLD;
          end else begin
            ptr <= ptr + PW'(1);
          end
        end
        HOLD: begin
          if (sample_now) begin
            sample_enable <= shadow;
            active_count  <= cnt;
            overflow      <= |(snap & ~shadow);
            state         <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - table-driven bench for voice_allocator with strobe-timing monitor
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [11:0] keys;
  logic        sample_now;
  logic [11:0] sample_enable;
  logic [2:0]  active_count;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  logic        auto_sn = 1'b0;
  int          sn_cnt  = 0;
  logic        mon_en  = 1'b0;
  logic        sn_seen = 1'b0;
  logic [11:0] se_last = '0;
  logic [2:0]  ac_last = '0;
  logic        ov_last = 1'b0;
  logic        glitch_bad;

  typedef struct packed {
    logic [11:0] k;
    logic [11:0] se;
    logic [2:0]  ac;
    logic        ov;
  } vec_t;

  vec_t vt [12];

  voice_allocator #(
    .NKEYS(12),
    .MAX_VOICES(4),
    .DB_CYCLES(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .keys(keys),
    .sample_now(sample_now),
    .sample_enable(sample_enable),
    .active_count(active_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic int pc12(input logic [11:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 12; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_sn();
    sample_now = 1'b1;
    @(negedge clk);
    sample_now = 1'b0;
  endtask

  // Free-running strobe: one cycle high every 50 cycles while enabled
  always @(negedge clk) begin
    if (auto_sn) begin
      sample_now = (sn_cnt == 49);
      sn_cnt     = (sn_cnt == 49) ? 0 : sn_cnt + 1;
    end
  end

  always @(posedge clk) sn_seen <= sample_now;

  // Outputs may only move right after a strobe, and the count must track the mask
  always @(negedge clk) begin
    if (mon_en) begin
      if ((sample_enable !== se_last || active_count !== ac_last || overflow !== ov_last) && !sn_seen) begin
        miscompares++;
        $display("FAIL update_timing: outputs changed to %h/%0d/%0d without a strobe (were %h/%0d/%0d)",
                 sample_enable, active_count, overflow, se_last, ac_last, ov_last);
      end
      if (int'(active_count) != pc12(sample_enable) || active_count > 3'd4) begin
        miscompares++;
        $display("FAIL invariant: active_count %0d, popcount(sample_enable=%h) %0d",
                 active_count, sample_enable, pc12(sample_enable));
      end
    end
    se_last = sample_enable;
    ac_last = active_count;
    ov_last = overflow;
  end

  initial begin
    vt[0]  = '{12'h200, 12'h200, 3'd1, 1'b0};
    vt[1]  = '{12'h000, 12'h000, 3'd0, 1'b0};
    vt[2]  = '{12'h0FF, 12'h00F, 3'd4, 1'b1};
    vt[3]  = '{12'h0FD, 12'h01D, 3'd4, 1'b1};
    vt[4]  = '{12'h0FD, 12'h01D, 3'd4, 1'b1};
    vt[5]  = '{12'h0FC, 12'h03C, 3'd4, 1'b1};
    vt[6]  = '{12'h800, 12'h800, 3'd1, 1'b0};
    vt[7]  = '{12'hF00, 12'hF00, 3'd4, 1'b0};
    vt[8]  = '{12'hFFF, 12'hF00, 3'd4, 1'b1};
    vt[9]  = '{12'h001, 12'h001, 3'd1, 1'b0};
    vt[10] = '{12'h00E, 12'h00E, 3'd3, 1'b0};
    vt[11] = '{12'h000, 12'h000, 3'd0, 1'b0};

    n_rst      = 1'b0;
    keys       = 12'hFFF;
    sample_now = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_se", sample_enable, 12'h000);
    chk("reset_ac", 12'(active_count), 12'h0);
    chk("reset_ov", 12'(overflow), 12'h0);

    n_rst   = 1'b1;
    auto_sn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (38) @(negedge clk);
    chk("pre_strobe_se", sample_enable, 12'h000);
    repeat (110) @(negedge clk);
    chk("after_reset_se", sample_enable, 12'h00F);
    chk("after_reset_ac", 12'(active_count), 12'h4);
    chk("after_reset_ov", 12'(overflow), 12'h1);

    for (int i = 0; i < 12; i++) begin
      keys = vt[i].k;
      repeat (150) @(negedge clk);
      chk($sformatf("vec%0d_se", i), sample_enable, vt[i].se);
      chk($sformatf("vec%0d_ac", i), 12'(active_count), 12'(vt[i].ac));
      chk($sformatf("vec%0d_ov", i), 12'(overflow), 12'(vt[i].ov));
    end

    for (int ph = 0; ph < 4; ph++) begin
      glitch_bad = 1'b0;
      repeat (ph + 1) @(negedge clk);
      keys = 12'h020;
      repeat (3) @(negedge clk);
      keys = 12'h000;
      repeat (120) begin
        @(negedge clk);
        if (sample_enable != 12'h000 || overflow) glitch_bad = 1'b1;
      end
      vectors++;
      if (glitch_bad) begin
        miscompares++;
        $display("FAIL glitch_phase%0d: got se=%h ov=%0d, expected se=000 ov=0", ph, sample_enable, overflow);
      end
    end

    auto_sn = 1'b0;
    @(negedge clk);
    sample_now = 1'b0;
    keys = 12'h030;
    repeat (30) @(negedge clk);
    pulse_sn();
    repeat (5) @(negedge clk);
    pulse_sn();
    repeat (20) @(negedge clk);
    chk("midscan_strobe_se", sample_enable, 12'h000);
    chk("midscan_strobe_ac", 12'(active_count), 12'h0);
    pulse_sn();
    @(negedge clk);
    chk("next_strobe_se", sample_enable, 12'h030);
    chk("next_strobe_ac", 12'(active_count), 12'h2);
    chk("next_strobe_ov", 12'(overflow), 12'h0);

    repeat (20) @(negedge clk);
    pulse_sn();
    repeat (3) @(negedge clk);
    #1;
    mon_en = 1'b0;
    n_rst  = 1'b0;
    #1;
    chk("midscan_reset_se", sample_enable, 12'h000);
    chk("midscan_reset_ac", 12'(active_count), 12'h0);
    chk("midscan_reset_ov", 12'(overflow), 12'h0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    pulse_sn();
    @(negedge clk);
    chk("restart_first_commit_se", sample_enable, 12'h000);
    sn_cnt  = 0;
    auto_sn = 1'b1;
    repeat (150) @(negedge clk);
    chk("restart_se", sample_enable, 12'h030);
    chk("restart_ac", 12'(active_count), 12'h2);
    chk("restart_ov", 12'(overflow), 12'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
